axi_wr_fifo_push: RTL

AXI4 write-channel slave that accepts one burst at a time and pushes every W beat into the downstream `sync_fifo` write port. It sits directly upstream of the FIFO. It converts AW/W/B handshakes into `wr_en`/`wr_data` strobes and uses the FIFO `full` flag as W-channel backpressure. It also checks each burst for WLAST and strobe consistency, and reports the result on the B channel.

---
 rtl/axi_wr_fifo_push.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axi_wr_fifo_push.sv
// AXI4 write-channel slave that feeds a sync_fifo write port.
// One burst is accepted at a time. Every W beat is pushed to the FIFO with
// zero added latency, and FIFO full is used as W backpressure. Each burst is
// checked for WLAST placement and full byte strobes, and the B channel
// reports OKAY or SLVERR.
module axi_wr_fifo_push #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [31:0]             s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic                    fifo_wr_en,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  input  logic                    fifo_full
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]          r_len;
  logic [7:0]          r_beat_cnt;
  logic                r_err;
  logic [31:0]         r_addr;
  logic                r_out_of_reset;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_last_beat;
  logic                w_strb_full;
  logic                w_unused_addr;

  assign w_aw_hs       = s_awvalid & s_awready;
  assign w_w_hs        = s_wvalid & s_wready;
  assign w_last_beat   = (r_beat_cnt == r_len);
  assign w_strb_full   = &s_wstrb;
  // The burst address is captured for visibility only; the FIFO has no
  // address steering.
  assign w_unused_addr = ^r_addr;

  // State register and burst bookkeeping.
  // r_out_of_reset holds awready low until the first clock edge after reset
  // is released, even though the FSM already sits in IDLE during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_id           <= '0;
      r_len          <= '0;
      r_beat_cnt     <= '0;
      r_err          <= 1'b0;
      r_addr         <= '0;
      r_out_of_reset <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_out_of_reset <= 1'b1;
      case (r_state)
        IDLE: begin
          r_beat_cnt <= '0;
          r_err      <= 1'b0;
          if (w_aw_hs) begin
            r_id   <= s_awid;
            r_len  <= s_awlen;
            r_addr <= s_awaddr;
          end
        end
        DATA: begin
          if (w_w_hs) begin
            // Hold on the final beat so a 256-beat burst never wraps to 0.
            if (!w_last_beat) begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if ((s_wlast != w_last_beat) || !w_strb_full) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and handshake/push outputs.
  always_comb begin
    w_state_nxt  = r_state;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bresp      = 2'b00;
    s_bid        = r_id;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = s_wdata;
    case (r_state)
      IDLE: begin
        s_awready = r_out_of_reset;
        if (w_aw_hs) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        s_wready   = !fifo_full;
        fifo_wr_en = w_w_hs;
        if (w_w_hs && w_last_beat) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = r_err ? 2'b10 : 2'b00;
        if (s_bready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
